// File: rtl/imem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_access_ctrl_if
//  Description : Bundle of the fetch-side, loader-side and memory-side
//                signals of the instruction-memory access controller.
//                  cpu_*  : fetch request / instruction return / stall
//                  ld_*   : loader read/write request / read word / stall
//                  mem_*  : memory strobes, word address, data, busywait
//                Modport slave  = controller view (serves cpu/ld, drives mem).
//                Modport master = environment view (requesters + memory).
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_access_ctrl_if;
  logic        cpu_read;
  logic [31:0] cpu_address;
  logic [31:0] cpu_readdata;
  logic        cpu_busywait;

  logic        ld_read;
  logic        ld_write;
  logic [31:0] ld_address;
  logic [31:0] ld_writedata;
  logic [31:0] ld_readdata;
  logic        ld_busywait;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport slave (
    input  cpu_read, cpu_address,
    output cpu_readdata, cpu_busywait,
    input  ld_read, ld_write, ld_address, ld_writedata,
    output ld_readdata, ld_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output cpu_read, cpu_address,
    input  cpu_readdata, cpu_busywait,
    output ld_read, ld_write, ld_address, ld_writedata,
    input  ld_readdata, ld_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface
`default_nettype wire

// File: rtl/imem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_access_ctrl
//  Description : Single-port arbiter/sequencer in front of the instruction
//                memory. Shares the memory between the fetch stage (read
//                only) and the program loader (read/write). The fetch stage
//                is held in stall until the loader reports boot completion.
//                Each access: grant edge -> ACC (strobes held through memory
//                busywait) -> RESP (one-cycle response slot).
//  Ports       : clock     - system clock, rising edge
//                reset     - asynchronous active-low reset
//                boot_done - loader finished writing the program (level)
//                booted    - high once run mode has been entered
//                bus       - cpu/ld/mem signal bundle (slave modport)
//  Revision    : 1.0  initial release
// ============================================================================
module imem_access_ctrl #(
  parameter int unsigned MAX_LD_STREAK = 8
) (
  input  wire               clock,
  input  wire               reset,
  input  wire               boot_done,
  output logic              booted,
  imem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    ACC  = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_LD  = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  localparam logic [7:0] c_streak_max = 8'(MAX_LD_STREAK);

  state_t      r_state,         w_state_nxt;
  owner_t      r_owner,         w_owner_nxt;
  logic        r_booted,        w_booted_nxt;
  logic [7:0]  r_streak,        w_streak_nxt;
  logic        r_mem_read,      w_mem_read_nxt;
  logic        r_mem_write,     w_mem_write_nxt;
  logic [31:0] r_mem_address,   w_mem_address_nxt;
  logic [31:0] r_mem_writedata, w_mem_writedata_nxt;
  logic [31:0] r_cpu_hold,      w_cpu_hold_nxt;
  logic [31:0] r_ld_hold,       w_ld_hold_nxt;

  logic w_ld_req;
  logic w_grant_ld;
  logic w_grant_cpu;
  logic w_resp_cpu;
  logic w_resp_ld;
  logic w_unused;

  // Simultaneous ld_read and ld_write is treated as a write.
  assign w_ld_req = bus.ld_read | bus.ld_write;

  // Byte-offset bits never reach the word-organised memory.
  assign w_unused = ^{bus.cpu_address[1:0], bus.ld_address[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= BOOT;
      r_owner         <= OWN_LD;
      r_booted        <= 1'b0;
      r_streak        <= 8'd0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= 32'd0;
      r_mem_writedata <= 32'd0;
      r_cpu_hold      <= 32'd0;
      r_ld_hold       <= 32'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_owner         <= w_owner_nxt;
      r_booted        <= w_booted_nxt;
      r_streak        <= w_streak_nxt;
      r_mem_read      <= w_mem_read_nxt;
      r_mem_write     <= w_mem_write_nxt;
      r_mem_address   <= w_mem_address_nxt;
      r_mem_writedata <= w_mem_writedata_nxt;
      r_cpu_hold      <= w_cpu_hold_nxt;
      r_ld_hold       <= w_ld_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_owner_nxt         = r_owner;
    w_booted_nxt        = r_booted;
    w_streak_nxt        = r_streak;
    w_mem_read_nxt      = r_mem_read;
    w_mem_write_nxt     = r_mem_write;
    w_mem_address_nxt   = r_mem_address;
    w_mem_writedata_nxt = r_mem_writedata;
    w_cpu_hold_nxt      = r_cpu_hold;
    w_ld_hold_nxt       = r_ld_hold;
    w_grant_ld          = 1'b0;
    w_grant_cpu         = 1'b0;

    case (r_state)
      BOOT: begin
        // A pending loader request takes precedence over entering run mode.
        if (w_ld_req) begin
          w_grant_ld = 1'b1;
        end else if (boot_done) begin
          w_booted_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      IDLE: begin
        // Loader has priority; a fetch is forced through once the loader
        // has won MAX_LD_STREAK consecutive grants against a pending fetch.
        if (bus.cpu_read && (!w_ld_req || (r_streak == c_streak_max))) begin
          w_grant_cpu = 1'b1;
        end else if (w_ld_req) begin
          w_grant_ld = 1'b1;
        end
      end
      ACC: begin
        if (!bus.mem_busywait) begin
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = RESP;
        end
      end
      RESP: begin
        // Holding register updates even if the requester has withdrawn.
        if (r_owner == OWN_CPU) begin
          w_cpu_hold_nxt = bus.mem_readdata;
        end else begin
          w_ld_hold_nxt = bus.mem_readdata;
        end
        w_state_nxt = r_booted ? IDLE : BOOT;
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase

    if (w_grant_ld) begin
      w_owner_nxt         = OWN_LD;
      w_mem_address_nxt   = {bus.ld_address[31:2], 2'b00};
      w_mem_writedata_nxt = bus.ld_writedata;
      w_mem_write_nxt     = bus.ld_write;
      w_mem_read_nxt      = !bus.ld_write;
      w_state_nxt         = ACC;
    end

    if (w_grant_cpu) begin
      w_owner_nxt       = OWN_CPU;
      w_mem_address_nxt = {bus.cpu_address[31:2], 2'b00};
      w_mem_read_nxt    = 1'b1;
      w_mem_write_nxt   = 1'b0;
      w_state_nxt       = ACC;
    end

    // Fairness counter only matters in run mode; boot-time loader grants
    // are not counted because the fetch stage cannot be served then anyway.
    if (!bus.cpu_read || w_grant_cpu) begin
      w_streak_nxt = 8'd0;
    end else if (w_grant_ld && (r_state == IDLE)) begin
      w_streak_nxt = r_streak + 8'd1;
    end
  end

  assign w_resp_cpu = (r_state == RESP) && (r_owner == OWN_CPU);
  assign w_resp_ld  = (r_state == RESP) && (r_owner == OWN_LD);

  // In the response slot the owner sees memory data directly; afterwards
  // the holding register keeps presenting it.
  assign bus.cpu_readdata  = w_resp_cpu ? bus.mem_readdata : r_cpu_hold;
  assign bus.ld_readdata   = w_resp_ld  ? bus.mem_readdata : r_ld_hold;
  assign bus.cpu_busywait  = bus.cpu_read & ~w_resp_cpu;
  assign bus.ld_busywait   = w_ld_req & ~w_resp_ld;

  assign bus.mem_read      = r_mem_read;
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_writedata = r_mem_writedata;

  assign booted = r_booted;

endmodule
`default_nettype wire

// File: tb/tb_imem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_access_ctrl
//  Description : Self-checking bench for imem_access_ctrl. A word memory
//                model with programmable busywait sits on the mem side;
//                expected read words are queued at issue time and popped by
//                a monitor whenever a requester sees its busywait drop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_access_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic boot_done;
  logic booted;

  imem_access_ctrl_if bus ();

  imem_access_ctrl #(.MAX_LD_STREAK(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .boot_done(boot_done),
    .booted   (booted),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [0:63];
  logic [63:0] mem_valid;
  logic [5:0]  idx;
  logic        strobe;
  int          stall_req;
  int          used;
  logic        unused_addr_hi;

  assign idx              = bus.mem_address[7:2];
  assign strobe           = bus.mem_read | bus.mem_write;
  assign bus.mem_busywait = strobe && (used < stall_req);
  assign unused_addr_hi   = ^{bus.mem_address[31:8], bus.mem_address[1:0]};

  // Unwritten words read back as 0xC0DE0000 | word index.
  always @(posedge clock) begin
    if (!reset) begin
      mem_valid        <= '0;
      used             <= 0;
      bus.mem_readdata <= 32'd0;
    end else begin
      if (!strobe) used <= 0;
      else if (used < stall_req) used <= used + 1;
      if (strobe && !(used < stall_req)) begin
        if (bus.mem_write) begin
          mem[idx]       <= bus.mem_writedata;
          mem_valid[idx] <= 1'b1;
        end else begin
          bus.mem_readdata <= mem_valid[idx] ? mem[idx] : (32'hC0DE0000 | {26'd0, idx});
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [31:0] cpu_exp[$];
  logic [31:0] ld_exp[$];

  always @(negedge clock) begin
    if (reset) begin
      if (bus.cpu_read && !bus.cpu_busywait) begin
        if (cpu_exp.size() == 0) begin
          errors++; checks++;
          $display("FAIL cpu_unexpected: got 0x%08h expected no response", bus.cpu_readdata);
        end else begin
          chk("cpu_rdata", bus.cpu_readdata, cpu_exp.pop_front());
        end
      end
      if (bus.ld_read && !bus.ld_write && !bus.ld_busywait) begin
        if (ld_exp.size() == 0) begin
          errors++; checks++;
          $display("FAIL ld_unexpected: got 0x%08h expected no response", bus.ld_readdata);
        end else begin
          chk("ld_rdata", bus.ld_readdata, ld_exp.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ld_wr(input logic [31:0] a, input logic [31:0] d);
    int st = 0;
    int wr = 0;
    int guard = 0;
    @(posedge clock); #1;
    bus.ld_write = 1'b1; bus.ld_address = a; bus.ld_writedata = d;
    do begin
      @(negedge clock); guard++;
      if (bus.mem_write) begin
        wr++;
        chk("ld_wr_addr", bus.mem_address, a);
      end
      if (bus.ld_busywait) st++;
    end while (bus.ld_busywait && guard < 50);
    chk("ld_wr_pulse", wr, 1);
    chk("ld_wr_stall", st, 2);
    @(posedge clock); #1;
    bus.ld_write = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [31:0] maddr,
                       input int exp_st, input int exp_rd);
    int st = 0;
    int rd = 0;
    int badaddr = 0;
    int guard = 0;
    @(posedge clock); #1;
    bus.cpu_read = 1'b1; bus.cpu_address = a;
    cpu_exp.push_back(d);
    do begin
      @(negedge clock); guard++;
      if (bus.mem_read) begin
        rd++;
        if (bus.mem_address !== maddr) badaddr++;
      end
      if (bus.cpu_busywait) st++;
    end while (bus.cpu_busywait && guard < 50);
    chk("fetch_stall", st, exp_st);
    chk("fetch_rd_cycles", rd, exp_rd);
    chk("fetch_addr_bad", badaddr, 0);
    @(posedge clock); #1;
    bus.cpu_read = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int    bw_bad, rd_seen, bt_seen, st, guard;
  string resp_log;

  initial begin
    reset = 1'b1; boot_done = 1'b0; stall_req = 0;
    bus.cpu_read = 1'b1; bus.cpu_address = 32'h0;
    bus.ld_read = 1'b0; bus.ld_write = 1'b0;
    bus.ld_address = 32'h0; bus.ld_writedata = 32'h0;
    #1 reset = 1'b0;
    #2;
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_writedata", bus.mem_writedata, 0);
    chk("rst_cpu_readdata", bus.cpu_readdata, 0);
    chk("rst_ld_readdata", bus.ld_readdata, 0);
    chk("rst_booted", booted, 0);
    chk("rst_cpu_busywait", bus.cpu_busywait, 1);
    chk("rst_ld_busywait", bus.ld_busywait, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Boot hold: fetch pending, no boot_done.
    bw_bad = 0; rd_seen = 0; bt_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (!bus.cpu_busywait) bw_bad++;
      if (bus.mem_read) rd_seen++;
      if (booted) bt_seen++;
    end
    chk("hold_busywait_low", bw_bad, 0);
    chk("hold_mem_read", rd_seen, 0);
    chk("hold_booted", bt_seen, 0);

    // Load program, then enter run mode; pending fetch from 0x0 completes.
    ld_wr(32'h0, 32'h00A00093);
    ld_wr(32'h4, 32'h00100113);
    boot_done = 1'b1;
    cpu_exp.push_back(32'h00A00093);
    @(negedge clock);
    chk("booted_before_edge", booted, 0);
    @(posedge clock); #1;
    chk("booted_rise", booted, 1);
    st = 0; guard = 0;
    do begin
      @(negedge clock); guard++;
      if (bus.cpu_busywait) st++;
    end while (bus.cpu_busywait && guard < 50);
    chk("run_fetch_stall", st, 2);
    @(posedge clock); #1;
    bus.cpu_read = 1'b0;
    boot_done = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk("booted_sticky", booted, 1);

    // Memory stall of 3 cycles on a fetch.
    stall_req = 3;
    fetch(32'h4, 32'h00100113, 32'h4, 5, 4);
    stall_req = 0;

    // Contention: loader streams reads while a fetch is pending.
    @(posedge clock); #1;
    bus.ld_read = 1'b1; bus.ld_address = 32'h8;
    bus.cpu_read = 1'b1; bus.cpu_address = 32'h0;
    for (int i = 0; i < 16; i++) ld_exp.push_back(32'hC0DE0002);
    for (int i = 0; i < 2; i++) cpu_exp.push_back(32'h00A00093);
    resp_log = ""; guard = 0;
    while (resp_log.len() < 18 && guard < 200) begin
      @(negedge clock); guard++;
      if (bus.cpu_read && !bus.cpu_busywait) resp_log = {resp_log, "C"};
      if (bus.ld_read && !bus.ld_busywait) resp_log = {resp_log, "L"};
    end
    checks++;
    if (resp_log != "LLLLLLLLCLLLLLLLLC") begin
      errors++;
      $display("FAIL contention_order: got %s expected LLLLLLLLCLLLLLLLLC", resp_log);
    end
    @(posedge clock); #1;
    bus.ld_read = 1'b0; bus.cpu_read = 1'b0;

    // Misaligned fetch drops the byte offset.
    fetch(32'h7, 32'h00100113, 32'h4, 2, 1);

    // Loader withdraws mid-access; next grant goes to the fetch.
    @(posedge clock); #1;
    bus.ld_read = 1'b1; bus.ld_address = 32'hC;
    @(posedge clock); #1;
    bus.ld_read = 1'b0;
    bus.cpu_read = 1'b1; bus.cpu_address = 32'h0;
    cpu_exp.push_back(32'h00A00093);
    @(negedge clock);
    chk("wd_acc_mem_read", bus.mem_read, 1);
    @(negedge clock);
    chk("wd_resp_mem_read", bus.mem_read, 0);
    chk("wd_resp_ld_readdata", bus.ld_readdata, 32'hC0DE0003);
    @(negedge clock);
    chk("wd_idle_mem_read", bus.mem_read, 0);
    chk("wd_hold_ld_readdata", bus.ld_readdata, 32'hC0DE0003);
    @(negedge clock);
    chk("wd_cpu_grant_read", bus.mem_read, 1);
    chk("wd_cpu_grant_addr", bus.mem_address, 32'h0);
    @(negedge clock);
    chk("wd_cpu_resp_busywait", bus.cpu_busywait, 0);
    @(posedge clock); #1;
    bus.cpu_read = 1'b0;

    // Asynchronous reset in the middle of a stalled loader write.
    stall_req = 5;
    @(posedge clock); #1;
    bus.ld_write = 1'b1; bus.ld_address = 32'h10; bus.ld_writedata = 32'hDEADBEEF;
    @(posedge clock); #1;
    chk("ar_mem_write_on", bus.mem_write, 1);
    chk("ar_mem_address", bus.mem_address, 32'h10);
    #2 reset = 1'b0;
    #1;
    chk("ar_mem_write_off", bus.mem_write, 0);
    chk("ar_mem_address_clr", bus.mem_address, 0);
    chk("ar_booted", booted, 0);
    chk("ar_cpu_readdata", bus.cpu_readdata, 0);
    chk("ar_ld_readdata", bus.ld_readdata, 0);
    bus.ld_write = 1'b0;
    stall_req = 0;
    bus.cpu_read = 1'b1; bus.cpu_address = 32'h0;
    @(posedge clock); #1 reset = 1'b1;
    rd_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.mem_read) rd_seen++;
    end
    chk("ar_back_in_boot", rd_seen, 0);
    bus.cpu_read = 1'b0;

    repeat (2) @(negedge clock);
    chk("cpu_queue_empty", cpu_exp.size(), 0);
    chk("ld_queue_empty", ld_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Single-port access controller in front of the word-organised instruction memory.
- Shares the memory between the CPU fetch stage (read-only) and the program loader (read/write), and holds the CPU in stall until the loader signals boot completion.
- Sequences each access:
  - registers the grant;
  - drives the memory request;
  - waits out memory busywait;
  - returns data with a one-cycle response slot.
- Sits between the IF pipeline stage / boot loader and the instruction memory.

Parameters:
MAX_LD_STREAK, 8, consecutive loader grants allowed in run mode while the CPU is pending before one CPU grant is forced (range 1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
boot_done  in  1  loader finished writing program; level, sampled in BOOT
booted  out  1  high once run mode entered
cpu_read  in  1  fetch request, held until busywait low
cpu_address  in  32  fetch byte address
cpu_readdata  out  32  fetched instruction
cpu_busywait  out  1  stall to fetch stage
ld_read  in  1  loader read request
ld_write  in  1  loader write request
ld_address  in  32  loader byte address
ld_writedata  in  32  loader write word
ld_readdata  out  32  loader read word
ld_busywait  out  1  stall to loader
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  32  word-aligned memory address
mem_writedata  out  32  memory write word
mem_readdata  in  32  memory read data, valid the cycle after the accepting edge
mem_busywait  in  1  memory not ready

Behaviour:

States are BOOT, IDLE, ACC and RESP, with an owner register (CPU or LD) and a mode bit `booted`.

Reset (reset low, asynchronous):
- State goes to BOOT; booted=0; owner=LD; streak=0.
- mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
- cpu_readdata=0 and ld_readdata=0 (holding registers).
- Busywaits follow the combinational rule below: cpu_busywait=cpu_read, ld_busywait=ld_read|ld_write.

Grant (from BOOT or IDLE, no access in flight):
- In BOOT, only the loader is granted.
- In IDLE, loader beats CPU unless streak==MAX_LD_STREAK and cpu_read is high; in that case CPU wins.
- Streak behaviour:
  - increments on a loader grant while cpu_read is high;
  - clears on a CPU grant or when cpu_read is low.
- On the grant edge:
  - latch owner;
  - mem_address={addr[31:2],2'b00};
  - latch mem_writedata;
  - register mem_write=ld_write, mem_read=!ld_write (CPU: mem_read=1);
  - go to ACC.
- ld_read and ld_write together are treated as a write.

ACC:
- Strobes and address stay stable.
- Requester address/data changes are ignored.
- Stays in ACC while mem_busywait is high.
- On an edge with mem_busywait low: strobes clear and state goes to RESP.

RESP (exactly 1 cycle):
- The owner's readdata output is combinationally mem_readdata.
- The owner's holding register loads mem_readdata at the exit edge and drives the output afterwards.
- The owner's busywait is low this cycle only.
- Next state: IDLE if booted, else BOOT.

BOOT to IDLE:
- Taken when in BOOT and boot_done=1 with no loader request granted that edge.
- booted goes to 1.
- Later changes of boot_done are ignored; only reset returns the block to BOOT.

Busywait rules:
- cpu_busywait = cpu_read & !(state==RESP & owner==CPU)
- ld_busywait = (ld_read|ld_write) & !(state==RESP & owner==LD)

Latency:
- With mem_busywait=0, a request first seen at edge N gets mem strobe high cycle N+1 and busywait low in cycle N+2, i.e. 2 stall cycles.
- Back-to-back fetch throughput is 1 word per 3 cycles.

Boundary conditions:
- Request withdrawn mid-access: the access completes; RESP still occurs; the holding register still updates.
- Address not word-aligned: low 2 bits are dropped.
- Reset during ACC: strobes drop immediately (asynchronously) and the in-flight write may be lost.
- No request in IDLE or BOOT: strobes stay 0.

Test Plan:
- Boot hold: release reset with cpu_read=1, addr 0x0, boot_done=0 for 20 cycles -> cpu_busywait=1 throughout, mem_read never asserted, booted=0.
- Load then run: loader writes 0x00A00093 to 0x0, then 0x00100113 to 0x4 (mem_busywait=0), then boot_done=1 -> each write shows mem_write 1 cycle, ld_busywait low in RESP; booted=1 one edge later; the pending fetch from 0x0 returns cpu_readdata=0x00A00093 with 2 stall cycles.
- Memory stall: fetch 0x4 with mem_busywait high 3 cycles -> mem_read and mem_address=0x4 held 4 cycles, cpu_busywait low exactly 1 cycle afterwards, data 0x00100113.
- Contention: in run mode, loader reads continuously and cpu_read=1, MAX_LD_STREAK=8 -> 8 loader grants, then 1 CPU grant, then loader resumes; streak resets.
- Misaligned/withdraw: fetch 0x7 -> mem_address=0x4. Loader drops ld_read in ACC -> RESP still one cycle, ld_readdata updated, next grant goes to the CPU.
- Async reset mid-ACC of a loader write -> mem_write=0 before the next clock edge, state BOOT, booted=0, cpu_readdata=0.
